// File: rtl/ula_multiciclo_pkg.sv
// Shared encodings for the multicycle ALU: OpALU codes, R-type funct codes, FSM states.
package ula_multiciclo_pkg;

  // OpALU encodings from the main control unit
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_FUNCT = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  // R-type funct codes
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMul  = 3'd1,
    StDiv  = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } state_e;

endpackage

// File: rtl/ula_multiciclo_if.sv
// Operation/result handshake bundle between the EX-stage control and the ALU.
interface ula_multiciclo_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       OpALU;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] outputULA;
  logic             zero;
  logic             overflow;
  logic             illegal;

  // Control/datapath side: presents operations, consumes results
  modport master (
    output in_valid, OpALU, funct, a, b, out_ready,
    input  in_ready, out_valid, outputULA, zero, overflow, illegal
  );

  // ALU side
  modport slave (
    input  in_valid, OpALU, funct, a, b, out_ready,
    output in_ready, out_valid, outputULA, zero, overflow, illegal
  );
endinterface

// File: rtl/ula_muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per cycle.
// Multiply leaves the product in {hi,lo}; divide leaves remainder in hi, quotient in lo.
module ula_muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic             div_q, div_d, busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   add_sum, rem_shift, rem_diff;
  logic             rem_ge;

  // One iteration step of either algorithm; start reloads the operands
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opb_d  = opb_q;
    div_d  = div_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;

    mcand     = lo_q[0] ? opb_q : {WIDTH{1'b0}};
    add_sum   = {1'b0, hi_q} + {1'b0, mcand};
    // Partial remainder needs one extra bit: 2*rem+1 can reach 2*divisor-1
    rem_shift = {hi_q, lo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    rem_ge    = rem_shift >= {1'b0, opb_q};

    if (start) begin
      hi_d   = '0;
      lo_d   = op_a;
      opb_d  = op_b;
      div_d  = is_div;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (div_q) begin
        hi_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], rem_ge};
      end else begin
        {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastCnt) busy_d = 1'b0;
    end
  end

  // Engine state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opb_q  <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opb_q  <= opb_d;
      div_q  <= div_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;
  // High during the cycle whose edge performs the final step
  assign done = busy_q && (cnt_q == LastCnt);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/ula_multiciclo.sv
// Multicycle EX-stage ALU: decodes OpALU/funct, registers results behind valid/ready,
// and runs MULT/DIV through the iterative engine with HI/LO commit in the FIX state.
module ula_multiciclo
  import ula_multiciclo_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic            clk,
  input logic            reset,
  ula_multiciclo_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_q, res_d, a_q, a_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
  logic             sa_q, sa_d, sb_q, sb_d, sgn_q, sgn_d, div_q, div_d, bz_q, bz_d;

  logic [WIDTH-1:0] sum, diff, sc_res, mag_a, mag_b;
  logic             add_ovf, sub_ovf, sc_ovf, sc_ill, iter, iter_div, iter_signed;
  logic             eng_start, eng_busy, eng_done;
  logic [WIDTH-1:0] eng_hi, eng_lo, quo, rem, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // Decode and single-cycle datapath on the live operands
  always_comb begin
    sc_res      = '0;
    sc_ovf      = 1'b0;
    sc_ill      = 1'b0;
    iter        = 1'b0;
    iter_div    = 1'b0;
    iter_signed = 1'b0;
    sum         = bus.a + bus.b;
    diff        = bus.a - bus.b;
    add_ovf     = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    sub_ovf     = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
    case (bus.OpALU)
      OP_ADD: sc_res = sum;
      OP_SUB: sc_res = diff;
      OP_FUNCT: begin
        case (bus.funct)
          F_ADD:   begin sc_res = sum;  sc_ovf = add_ovf; end
          F_ADDU:  sc_res = sum;
          F_SUB:   begin sc_res = diff; sc_ovf = sub_ovf; end
          F_SUBU:  sc_res = diff;
          F_AND:   sc_res = bus.a & bus.b;
          F_OR:    sc_res = bus.a | bus.b;
          F_XOR:   sc_res = bus.a ^ bus.b;
          F_NOR:   sc_res = ~(bus.a | bus.b);
          F_SLT:   sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
          F_SLTU:  sc_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
          F_MFHI:  sc_res = hi_q;
          F_MFLO:  sc_res = lo_q;
          F_MULT:  begin iter = 1'b1; iter_signed = 1'b1; end
          F_MULTU: iter = 1'b1;
          F_DIV:   begin iter = 1'b1; iter_div = 1'b1; iter_signed = 1'b1; end
          F_DIVU:  begin iter = 1'b1; iter_div = 1'b1; end
          default: sc_ill = 1'b1;
        endcase
      end
      default: sc_ill = 1'b1;
    endcase
    mag_a = (iter_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b = (iter_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // Sign correction of the raw engine result, consumed in FIX
  always_comb begin
    prod     = {eng_hi, eng_lo};
    prod_fix = (sgn_q && (sa_q ^ sb_q)) ? -prod : prod;
    quo      = (sgn_q && (sa_q ^ sb_q)) ? -eng_lo : eng_lo;
    rem      = (sgn_q && sa_q) ? -eng_hi : eng_hi;
    if (!div_q) begin
      {fix_hi, fix_lo} = prod_fix;
    end else if (bz_q) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else begin
      fix_hi = rem;
      fix_lo = quo;
    end
  end

  // Handshake FSM next-state and result registers
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    res_d     = res_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    ill_d     = ill_q;
    a_d       = a_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    sgn_d     = sgn_q;
    div_d     = div_q;
    bz_d      = bz_q;
    eng_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (iter) begin
            a_d       = bus.a;
            sa_d      = bus.a[WIDTH-1];
            sb_d      = bus.b[WIDTH-1];
            sgn_d     = iter_signed;
            div_d     = iter_div;
            bz_d      = (bus.b == '0);
            eng_start = 1'b1;
            state_d   = iter_div ? StDiv : StMul;
          end else begin
            res_d   = sc_res;
            zero_d  = (sc_res == '0);
            ovf_d   = sc_ovf;
            ill_d   = sc_ill;
            state_d = StDone;
          end
        end
      end
      StMul, StDiv: begin
        if (eng_busy && eng_done) state_d = StFix;
      end
      StFix: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        res_d   = fix_lo;
        zero_d  = 1'b0;
        ovf_d   = 1'b0;
        ill_d   = 1'b0;
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset aborts any iteration in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
      a_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sgn_q   <= 1'b0;
      div_q   <= 1'b0;
      bz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
      a_q     <= a_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sgn_q   <= sgn_d;
      div_q   <= div_d;
      bz_q    <= bz_d;
    end
  end

  ula_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (eng_start),
    .is_div (iter_div),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .busy   (eng_busy),
    .done   (eng_done),
    .hi     (eng_hi),
    .lo     (eng_lo)
  );

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.outputULA = res_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed bench for ula_multiciclo: vector table plus hand-written multi-cycle sequences.
module tb_ula_multiciclo;
  import ula_multiciclo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  ula_multiciclo_if #(.WIDTH(32)) bus ();

  ula_multiciclo #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic z,
                              input logic o, input logic il, input int lat);
    vec_t v;
    v.op = op; v.f = f; v.a = a; v.b = b; v.res = res;
    v.z = z; v.o = o; v.il = il; v.lat = lat;
    return v;
  endfunction

  // Present one op from idle (called #1 after a posedge), wait bounded for the result, consume it
  task automatic run_op(input logic [1:0] op, input logic [5:0] f, input logic [31:0] aa,
                        input logic [31:0] bb, output logic [31:0] r, output logic z,
                        output logic o, output logic il, output int lat, output logic rdy_seen);
    bus.OpALU = op; bus.funct = f; bus.a = aa; bus.b = bb; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Scramble inputs to show operands were latched
    bus.a = $urandom; bus.b = $urandom; bus.funct = 6'h3f; bus.OpALU = 2'b11;
    lat = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.in_ready) rdy_seen = 1'b1;
    r = bus.outputULA; z = bus.zero; o = bus.overflow; il = bus.illegal;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  logic [31:0] r;
  logic        z, o, il, rdy;
  int          lat;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.OpALU = 2'b00; bus.funct = '0;
    bus.a = '0; bus.b = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_output", bus.outputULA, 32'd0);
    check("rst_flags", {29'b0, bus.zero, bus.overflow, bus.illegal}, 32'd0);
    #3 reset = 1'b0;
    @(posedge clk); #1;

    // lw/sw add, then hold the result with out_ready low
    bus.OpALU = OP_ADD; bus.a = 32'd3; bus.b = 32'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = 32'h55; bus.b = 32'h77;
    check("add00_valid", {31'b0, bus.out_valid}, 32'd1);
    check("add00_res", bus.outputULA, 32'd6);
    check("add00_zero", {31'b0, bus.zero}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
      check($sformatf("hold%0d_res", i), bus.outputULA, 32'd6);
      check($sformatf("hold%0d_in_ready", i), {31'b0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_valid", {31'b0, bus.out_valid}, 32'd0);
    check("release_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Order matters: MFHI/MFLO rows read HI/LO left by the preceding iterative row
    vecs.push_back(mk(OP_FUNCT, F_SUB,   32'd1,        32'd3,        32'hFFFFFFFE, 0, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_ADD,   32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 1, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_ADDU,  32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 0, 0, 1));
    vecs.push_back(mk(OP_ADD,   F_ADD,   32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SUB,   6'h00,   32'd5,        32'd5,        32'h00000000, 1, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_SUB,   32'h80000000, 32'd1,        32'h7FFFFFFF, 0, 1, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_SUBU,  32'h80000000, 32'd1,        32'h7FFFFFFF, 0, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        0, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0,        1, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_AND,   32'd3,        32'd1,        32'd1,        0, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_OR,    32'hF0,       32'h0F,       32'hFF,       0, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_XOR,   32'hFF,       32'h0F,       32'hF0,       0, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_NOR,   32'd0,        32'd0,        32'hFFFFFFFF, 0, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 0, 0, 0, 34));
    vecs.push_back(mk(OP_FUNCT, F_MFHI,  32'd0,        32'd0,        32'hFFFFFFFF, 0, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_MFLO,  32'd0,        32'd0,        32'hFFFFFFEB, 0, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0, 0, 34));
    vecs.push_back(mk(OP_FUNCT, F_MFLO,  32'd0,        32'd0,        32'hFFFFFFFD, 0, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_MFHI,  32'd0,        32'd0,        32'hFFFFFFFF, 0, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 0, 0, 0, 34));
    vecs.push_back(mk(OP_FUNCT, F_MFHI,  32'd0,        32'd0,        32'd5,        0, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        0, 0, 0, 34));
    vecs.push_back(mk(OP_FUNCT, F_MFHI,  32'd0,        32'd0,        32'hFFFFFFFE, 0, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 0, 34));
    vecs.push_back(mk(OP_FUNCT, F_MFHI,  32'd0,        32'd0,        32'd0,        1, 0, 0, 1));
    vecs.push_back(mk(OP_FUNCT, F_DIVU,  32'd100,      32'd7,        32'd14,       0, 0, 0, 34));
    vecs.push_back(mk(OP_ILL,   F_ADD,   32'd9,        32'd9,        32'd0,        1, 0, 1, 1));
    vecs.push_back(mk(OP_FUNCT, F_MFHI,  32'd0,        32'd0,        32'd2,        0, 0, 0, 1));

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].f, vecs[i].a, vecs[i].b, r, z, o, il, lat, rdy);
      check($sformatf("v%0d_res", i), r, vecs[i].res);
      check($sformatf("v%0d_flags", i), {29'b0, z, o, il}, {29'b0, vecs[i].z, vecs[i].o, vecs[i].il});
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      if (vecs[i].lat > 1) check($sformatf("v%0d_busy_in_ready", i), {31'b0, rdy}, 32'd0);
    end

    // Async reset ten cycles into a MULTU aborts it and clears HI/LO
    bus.OpALU = OP_FUNCT; bus.funct = F_MULTU; bus.a = 32'd5; bus.b = 32'd6; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("mid_mul_in_ready", {31'b0, bus.in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    run_op(OP_FUNCT, F_MFHI, 32'd0, 32'd0, r, z, o, il, lat, rdy);
    check("abort_mfhi", r, 32'd0);
    run_op(OP_FUNCT, F_MFLO, 32'd0, 32'd0, r, z, o, il, lat, rdy);
    check("abort_mflo", r, 32'd0);
    run_op(OP_FUNCT, 6'b111111, 32'd4, 32'd4, r, z, o, il, lat, rdy);
    check("ill_funct_res", r, 32'd0);
    check("ill_funct_flags", {29'b0, z, o, il}, 32'b101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
- Parametrised successor to the single-cycle ULA/ALU-control pair.
- Decodes OpALU/funct internally and registers every result behind a valid/ready handshake.
- Adds iterative MULT/MULTU/DIV/DIVU with HI/LO registers, plus MFHI/MFLO.
- Sits in the EX stage of the multicycle MIPS datapath. The control FSM stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, even).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation.
- OpALU  in  2  00 add (lw/sw), 01 sub (beq), 10 decode funct, 11 illegal.
- funct  in  6  R-type function field.
- a  in  WIDTH  operand rs.
- b  in  WIDTH  operand rt.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer accepts result.
- outputULA  out  WIDTH  result.
- zero  out  1  outputULA == 0.
- overflow  out  1  signed overflow (ADD/SUB funct only).
- illegal  out  1  unsupported OpALU/funct.

Behaviour:
- Reset (async, any state): state=IDLE; HI=LO=0; outputULA=0; zero=0; overflow=0; illegal=0; out_valid=0; in_ready=1.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- in_ready = (state==IDLE). An operation is accepted on the clk edge where in_valid && in_ready.
- Single-cycle ops: IDLE -> DONE. The result is registered at acceptance, so out_valid rises the next cycle (latency 1).
- Single-cycle funct set (OpALU=10):
  - 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
  - 101010 SLT (signed), 101011 SLTU (unsigned).
  - 010000 MFHI, 010010 MFLO.
- OpALU=00 is an add and OpALU=01 is a subtract; both ignore funct and never flag overflow.
- Arithmetic is modulo 2^WIDTH.
- overflow is set for ADD when both operand signs match and the result sign differs. It is set for SUB when the operand signs differ and the result sign differs from a.
- SLT/SLTU return zero-extended 0 or 1.
- Iterative ops:
  - 011000 MULT and 011001 MULTU: IDLE -> MUL.
  - 011010 DIV and 011011 DIVU: IDLE -> DIV.
- MUL/DIV run exactly WIDTH cycles, one bit per cycle: shift-add multiply, restoring divide, both on operand magnitudes.
- Signed variants take magnitudes at acceptance. FIX (1 cycle) applies sign correction:
  - product negated if a^b sign is 1;
  - quotient negated if the signs differ;
  - remainder takes the sign of a.
- FIX writes {HI,LO}: product high/low for multiply, HI=remainder and LO=quotient for divide. It then goes to DONE.
- Iterative latency is acceptance to out_valid = WIDTH+2 cycles. outputULA = LO, zero/overflow/illegal = 0.
- Divide by zero: HI=a, LO=all ones, no flag, same latency.
- DIV of most-negative by -1: LO=most-negative, HI=0, no flag.
- DONE: out_valid=1 and all outputs stable until out_ready. On the edge with out_ready, go to IDLE and clear out_valid.
- Back-to-back throughput is therefore one op per 2 cycles minimum.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Operands are latched at acceptance; changes on a/b/funct during MUL/DIV/DONE have no effect.
- Illegal: OpALU=11 or an unlisted funct goes to DONE with outputULA=0, illegal=1, zero=1. HI/LO are unchanged.
- MFHI/MFLO read the HI/LO values committed by the last completed FIX.
- Reset asserted mid-MUL/DIV aborts the operation; HI/LO return to 0.

Decomposition:
- Shared package holds:
  - OpALU encodings (OP_ADD, OP_SUB, OP_FUNCT, OP_ILL);
  - all funct localparams;
  - FSM state encodings.
- One sub-module: ula_muldiv_iter. It holds the iterative shift-add/restoring engine with start/busy/done, operand magnitudes in, and raw {hi,lo} out.
- Sign correction and handshake stay in the top.

Test Plan:
- Reset then OpALU=00, a=3, b=3 -> one cycle later out_valid=1, outputULA=6, zero=0. Hold out_ready=0 for 3 cycles: outputs stable.
- OpALU=10, funct=100010, a=1, b=3 -> outputULA=0xFFFFFFFE, overflow=0. ADD a=0x7FFFFFFF, b=1 -> outputULA=0x80000000, overflow=1. ADDU with the same operands -> overflow=0.
- SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0. AND 3&1 -> 1. NOR 0,0 -> 0xFFFFFFFF.
- MULT a=-3, b=7 -> out_valid exactly 34 cycles after acceptance. Then MFHI -> 0xFFFFFFFF and MFLO -> 0xFFFFFFEB. in_ready=0 throughout.
- DIV a=-7, b=2 -> MFLO=0xFFFFFFFD, MFHI=0xFFFFFFFF. DIVU a=5, b=0 -> LO=0xFFFFFFFF, HI=5.
- Assert reset at cycle 10 of a MULTU -> in_ready=1, out_valid=0 immediately (async), MFHI=0. funct=111111 -> illegal=1, outputULA=0.
